// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared types, constants and helpers for the FIFO word packer.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Packer FSM encoding: an explicit one-bit state type.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } packer_state_t;

    // Default header width and tag prepended to each readout word.
    localparam int         HDR_BITS_DEFAULT = 2;
    localparam logic [1:0] HDR_TAG_DEFAULT  = 2'b11;

    // Bytes needed to carry one header-tagged word, rounded up.
    function automatic int nbytes(input int width, input int hdr);
        return (width + hdr + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer
// Brief    : Pops words from a fall-through FIFO, prepends a header tag and
//            streams each frame MSB-first as bytes over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int                  WIDTH     = 30,
    parameter int                  HDR_BITS  = HDR_BITS_DEFAULT,
    parameter logic [HDR_BITS-1:0] HDR_TAG   = HDR_TAG_DEFAULT,
    parameter int                  NBYTES    = nbytes(WIDTH, HDR_BITS),
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_sent
);

    localparam int                FRAME_W  = NBYTES * 8;
    localparam int                IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

    packer_state_t         r_state;
    packer_state_t         w_next_state;
    logic [FRAME_W-1:0]    r_frame;
    logic [FRAME_W-1:0]    w_load;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_WIDTH-1:0]  r_words_sent;
    logic                  w_accept;
    logic                  w_last_accept;
    logic                  w_pop;

    // Handshake qualifiers: a byte moves only while a frame is in flight.
    assign w_accept      = (r_state == SEND) && out_ready;
    assign w_last_accept = w_accept && (r_idx == LAST_IDX);

    // Frame image: tag and word left-aligned, zero padding in the low bits.
    always_comb begin
        w_load = '0;
        w_load[FRAME_W-1 -: WIDTH+HDR_BITS] = {HDR_TAG, fifo_data};
    end

    // State register.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a pop always lands in SEND; the last accept without a pop returns to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if (w_last_accept && !w_pop) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Pop strobe: idle, or on the last-byte accept for a bubble-free follow-on word.
    always_comb begin
        w_pop = 1'b0;
        if (enable && !fifo_empty) begin
            w_pop = (r_state == IDLE) || w_last_accept;
        end
    end

    // Frame shifter, byte index and sent-word counter.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_frame      <= '0;
            r_idx        <= '0;
            r_words_sent <= '0;
        end else begin
            if (w_pop) begin
                r_frame <= w_load;
                r_idx   <= '0;
            end else if (w_accept) begin
                // Shifting the last byte out leaves an all-zero frame in IDLE.
                r_frame <= r_frame << 8;
                r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
            if (w_last_accept) begin
                r_words_sent <= r_words_sent + CNT_WIDTH'(1);
            end
        end
    end

    // The output byte is the top of the shift register, so it is registered and
    // only moves on an accept or a load.
    assign out_data   = r_frame[FRAME_W-1 -: 8];
    assign out_valid  = (r_state == SEND);
    assign busy       = (r_state != IDLE);
    assign fifo_rd    = w_pop;
    assign words_sent = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_word_packer
// Brief    : Self-checking bench for fifo_word_packer (CNT_WIDTH=4 build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;
    import fifo_pkg::*;

    localparam int WIDTH     = 30;
    localparam int CNT_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 res_n;
    logic                 enable;
    logic [WIDTH-1:0]     fifo_data;
    logic                 fifo_empty;
    logic                 fifo_rd;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic [CNT_WIDTH-1:0] words_sent;

    always #5 clk = ~clk;

    fifo_word_packer #(
        .WIDTH     (WIDTH),
        .HDR_BITS  (2),
        .HDR_TAG   (2'b11),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .enable     (enable),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .words_sent (words_sent)
    );

    typedef struct {
        logic [29:0] word;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

    vec_t        vecs[6];
    exp_t        exp_q[$];
    logic [29:0] fifo_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pops     = 0;
    int          acc_cnt  = 0;
    int          cyc      = 0;
    int          acc_times[$];
    bit          pop_pend = 0;
    bit          pop_prev = 0;
    bit          prev_valid = 0;
    bit          prev_ready = 0;
    logic [7:0]  prev_data = 8'h00;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    function automatic void fifo_drive();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 30'($urandom) : fifo_q[0];
    endfunction

    function automatic void push_word(input logic [29:0] w, input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2, input logic [7:0] b3);
        fifo_q.push_back(w);
        exp_q.push_back('{b0, 1'b0});
        exp_q.push_back('{b1, 1'b0});
        exp_q.push_back('{b2, 1'b0});
        exp_q.push_back('{b3, 1'b1});
        fifo_drive();
    endfunction

    function automatic void push_rand();
        logic [29:0] w;
        logic [31:0] f;
        w = 30'($urandom);
        f = {2'b11, w};
        push_word(w, f[31:24], f[23:16], f[15:8], f[7:0]);
    endfunction

    // FIFO model: a pop seen before the edge removes the head after the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (pop_pend) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                pop_pend = 0;
            end
            #1;
            fifo_drive();
        end
    end

    // Monitor on the falling edge: scoreboard, hold stability, pop legality.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (res_n) begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (pop_prev) check("first_byte_latency", 32'(out_valid), 32'd1);
            if (fifo_rd) begin
                pops++;
                pop_pend = 1;
                check("pop_not_empty", 32'(fifo_empty), 32'd0);
                if (busy)
                    check("pop_on_last_accept",
                          32'(out_valid && out_ready && exp_q.size() > 0 && exp_q[0].last), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h required none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'(out_data), 32'(e.data));
                    acc_cnt++;
                    acc_times.push_back(cyc);
                end
            end
        end
        prev_valid = out_valid && res_n;
        prev_ready = out_ready;
        prev_data  = out_data;
        pop_prev   = fifo_rd && res_n;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int target, input int limit, input string name);
        int k = 0;
        while (acc_cnt < target && k < limit) begin
            tick(1);
            k++;
        end
        check(name, 32'(acc_cnt), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0;
        int p0;
        vecs[0] = '{30'h2ABCDEF1, 8'hEA, 8'hBC, 8'hDE, 8'hF1};
        vecs[1] = '{30'h00000000, 8'hC0, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{30'h3FFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{30'h12345678, 8'hD2, 8'h34, 8'h56, 8'h78};
        vecs[4] = '{30'h15555555, 8'hD5, 8'h55, 8'h55, 8'h55};
        vecs[5] = '{30'h0A5A5A5A, 8'hCA, 8'h5A, 8'h5A, 8'h5A};

        res_n = 1'b0; enable = 1'b0; out_ready = 1'b0;
        fifo_drive();
        tick(3);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_words_sent", 32'(words_sent), 32'd0);
        @(negedge clk); #1 res_n = 1'b1;
        tick(1);

        // Single word.
        enable = 1'b1; out_ready = 1'b1;
        a0 = acc_cnt; p0 = pops;
        push_word(vecs[0].word, vecs[0].b0, vecs[0].b1, vecs[0].b2, vecs[0].b3);
        wait_acc(a0 + 4, 50, "t1_bytes");
        tick(2);
        check("t1_pops", 32'(pops), 32'(p0 + 1));
        check("t1_words", 32'(words_sent), 32'd1);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_valid_low", 32'(out_valid), 32'd0);

        // Back-to-back table words.
        a0 = acc_cnt; p0 = pops;
        acc_times.delete();
        for (int i = 1; i < 6; i++)
            push_word(vecs[i].word, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
        wait_acc(a0 + 20, 100, "t2_bytes");
        tick(2);
        check("t2_pops", 32'(pops), 32'(p0 + 5));
        if (acc_times.size() >= 20)
            check("t2_no_gap", 32'(acc_times[19] - acc_times[0]), 32'd19);
        check("t2_words", 32'(words_sent), 32'd6);

        // Back-pressure during byte1 with another word waiting.
        a0 = acc_cnt; p0 = pops;
        push_rand(); push_rand();
        wait_acc(a0 + 1, 50, "t3_byte0");
        out_ready = 1'b0;
        tick(5);
        check("t3_valid_held", 32'(out_valid), 32'd1);
        check("t3_byte1_held", 32'(out_data), 32'(exp_q[0].data));
        check("t3_no_extra_pop", 32'(pops), 32'(p0 + 1));
        check("t3_no_accept", 32'(acc_cnt), 32'(a0 + 1));
        out_ready = 1'b1;
        wait_acc(a0 + 8, 50, "t3_bytes");
        tick(2);
        check("t3_pops", 32'(pops), 32'(p0 + 2));
        check("t3_words", 32'(words_sent), 32'd8);

        // Enable drop at byte2 with the FIFO non-empty.
        a0 = acc_cnt; p0 = pops;
        push_rand(); push_rand(); push_rand();
        wait_acc(a0 + 2, 50, "t4_byte2");
        enable = 1'b0;
        wait_acc(a0 + 4, 50, "t4_frame_done");
        tick(3);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_no_pop", 32'(fifo_rd), 32'd0);
        check("t4_pops", 32'(pops), 32'(p0 + 1));
        check("t4_fifo_left", 32'(fifo_q.size()), 32'd2);
        check("t4_words", 32'(words_sent), 32'd9);
        enable = 1'b1;
        wait_acc(a0 + 12, 100, "t4_resume");
        tick(2);
        check("t4_pops_resume", 32'(pops), 32'(p0 + 3));
        check("t4_words_resume", 32'(words_sent), 32'd11);

        // Empty FIFO: no pop ever.
        p0 = pops;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            check("t5_no_rd", 32'(fifo_rd), 32'd0);
        end
        check("t5_pops", 32'(pops), 32'(p0));

        // Reset in the middle of a frame.
        a0 = acc_cnt;
        push_rand();
        wait_acc(a0 + 1, 50, "t5_byte0");
        res_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'd0);
        check("t5_rst_words", 32'(words_sent), 32'd0);
        exp_q.delete();
        tick(2);
        @(negedge clk); #1 res_n = 1'b1;
        tick(1);

        // Counter wrap at CNT_WIDTH=4: 15, 0, 1.
        a0 = acc_cnt;
        for (int i = 0; i < 15; i++) push_rand();
        wait_acc(a0 + 60, 200, "t6_bytes15");
        tick(2);
        check("t6_words15", 32'(words_sent), 32'd15);
        push_rand();
        wait_acc(a0 + 64, 50, "t6_bytes16");
        tick(2);
        check("t6_wrap0", 32'(words_sent), 32'd0);
        push_rand();
        wait_acc(a0 + 68, 50, "t6_bytes17");
        tick(2);
        check("t6_words17", 32'(words_sent), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
